// File: rtl/mem_wb_pipe_if.sv
// Pipeline-side bundle for mem_wb_pipe: EX/ID inputs, data-memory handshake, forwarding/writeback and stall outputs.
// Latency: none (wires only).
// Backpressure: dm_ready from memory drives the stall_* outputs back to the front end.
`timescale 1ns/1ps
interface mem_wb_pipe_if #(parameter int PERF_W = 32);
    logic              ex_valid;
    logic              ex_rf_we;
    logic [4:0]        ex_rf_wa;
    logic [31:0]       ex_alu_res;
    logic              ex_is_load;
    logic              ex_is_store;
    logic [31:0]       ex_st_data;
    logic [4:0]        id_ra0;
    logic [4:0]        id_ra1;
    logic              dm_ready;
    logic [31:0]       dm_rdata;
    logic              dm_req;
    logic              dm_we;
    logic [31:0]       dm_addr;
    logic [31:0]       dm_wdata;
    logic              rf_we_mem;
    logic [4:0]        rf_wa_mem;
    logic [31:0]       rf_wd_mem;
    logic              rf_we_wb;
    logic [4:0]        rf_wa_wb;
    logic [31:0]       rf_wd_wb;
    logic              stall_if;
    logic              stall_id;
    logic              stall_ex;
    logic              flush_ex;
    logic [PERF_W-1:0] perf_stall;

    // Pipeline block view
    modport slave (
        input  ex_valid, ex_rf_we, ex_rf_wa, ex_alu_res, ex_is_load, ex_is_store, ex_st_data,
               id_ra0, id_ra1, dm_ready, dm_rdata,
        output dm_req, dm_we, dm_addr, dm_wdata,
               rf_we_mem, rf_wa_mem, rf_wd_mem, rf_we_wb, rf_wa_wb, rf_wd_wb,
               stall_if, stall_id, stall_ex, flush_ex, perf_stall
    );

    // Surrounding core / memory view
    modport master (
        output ex_valid, ex_rf_we, ex_rf_wa, ex_alu_res, ex_is_load, ex_is_store, ex_st_data,
               id_ra0, id_ra1, dm_ready, dm_rdata,
        input  dm_req, dm_we, dm_addr, dm_wdata,
               rf_we_mem, rf_wa_mem, rf_wd_mem, rf_we_wb, rf_wa_wb, rf_wd_wb,
               stall_if, stall_id, stall_ex, flush_ex, perf_stall
    );
endinterface

// File: rtl/mem_wb_pipe.sv
// EX/MEM and MEM/WB pipeline registers with data-memory handshake, load-use detection and stall counter.
// Latency: 1 cycle EX->MEM, 1 cycle MEM->WB; memory request outputs are combinational from EX/MEM.
// Backpressure: dm_ready low on a load/store freezes EX/MEM, stalls IF/ID/EX and feeds bubbles into WB.
`timescale 1ns/1ps
module mem_wb_pipe #(
    parameter int PERF_W = 32
) (
    input  logic         clk,
    input  logic         rstn,
    mem_wb_pipe_if.slave bus
);

    typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

    state_t            state_q, state_d;

    logic              mem_valid_q, mem_rf_we_q, mem_is_load_q, mem_is_store_q;
    logic [4:0]        mem_rf_wa_q;
    logic [31:0]       mem_alu_res_q, mem_st_data_q;

    logic              wb_valid_q, wb_rf_we_q;
    logic [4:0]        wb_rf_wa_q;
    logic [31:0]       wb_wd_q;
    logic              wb_valid_d, wb_rf_we_d;
    logic [4:0]        wb_rf_wa_d;
    logic [31:0]       wb_wd_d;

    logic [PERF_W-1:0] perf_q, perf_d;

    logic              mem_acc;
    logic              mem_stall;
    logic              load_use;
    logic              stall_front;

    // A valid load/store sitting in MEM is a memory request; it stalls until the memory answers.
    assign mem_acc   = mem_valid_q & (mem_is_load_q | mem_is_store_q);
    assign mem_stall = mem_acc & ~bus.dm_ready;

    // Load in EX whose destination is read by the instruction in ID; x0 never counts.
    assign load_use  = bus.ex_valid & bus.ex_is_load & bus.ex_rf_we & (bus.ex_rf_wa != 5'd0)
                     & ((bus.ex_rf_wa == bus.id_ra0) | (bus.ex_rf_wa == bus.id_ra1));

    assign bus.dm_req    = mem_acc;
    assign bus.dm_we     = mem_is_store_q;
    assign bus.dm_addr   = mem_alu_res_q;
    assign bus.dm_wdata  = mem_st_data_q;

    // Loads are never forwarded from MEM: their data only exists once they reach WB.
    assign bus.rf_we_mem = mem_valid_q & mem_rf_we_q & ~mem_is_load_q & (mem_rf_wa_q != 5'd0);
    assign bus.rf_wa_mem = mem_rf_wa_q;
    assign bus.rf_wd_mem = mem_alu_res_q;

    assign bus.rf_we_wb  = wb_valid_q & wb_rf_we_q & (wb_rf_wa_q != 5'd0);
    assign bus.rf_wa_wb  = wb_rf_wa_q;
    assign bus.rf_wd_wb  = wb_wd_q;

    assign bus.perf_stall = perf_q;
    assign stall_front    = bus.stall_if;

    // Wait-state tracking plus stall/flush decode; a memory stall outranks a load-use bubble.
    always_comb begin
        state_d      = state_q;
        bus.stall_if = 1'b0;
        bus.stall_id = 1'b0;
        bus.stall_ex = 1'b0;
        bus.flush_ex = 1'b0;
        unique case (state_q)
            ST_IDLE: if (mem_stall)    state_d = ST_WAIT;
            ST_WAIT: if (bus.dm_ready) state_d = ST_IDLE;
            default:                   state_d = ST_IDLE;
        endcase
        if (mem_stall) begin
            bus.stall_if = 1'b1;
            bus.stall_id = 1'b1;
            bus.stall_ex = 1'b1;
        end else if (load_use) begin
            bus.stall_if = 1'b1;
            bus.stall_id = 1'b1;
            bus.flush_ex = 1'b1;
        end
    end

    // MEM/WB next value: bubble while memory stalls, otherwise the MEM instruction with its result.
    always_comb begin
        wb_valid_d = mem_valid_q;
        wb_rf_we_d = mem_rf_we_q;
        wb_rf_wa_d = mem_rf_wa_q;
        wb_wd_d    = mem_is_load_q ? bus.dm_rdata : mem_alu_res_q;
        if (mem_stall) begin
            wb_valid_d = 1'b0;
            wb_rf_we_d = 1'b0;
        end
        perf_d = perf_q + PERF_W'(stall_front);
    end

    // EX/MEM register, frozen while the memory access is outstanding.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem_valid_q    <= 1'b0;
            mem_rf_we_q    <= 1'b0;
            mem_rf_wa_q    <= 5'd0;
            mem_alu_res_q  <= 32'd0;
            mem_is_load_q  <= 1'b0;
            mem_is_store_q <= 1'b0;
            mem_st_data_q  <= 32'd0;
        end else if (!mem_stall) begin
            mem_valid_q    <= bus.ex_valid;
            mem_rf_we_q    <= bus.ex_rf_we;
            mem_rf_wa_q    <= bus.ex_rf_wa;
            mem_alu_res_q  <= bus.ex_alu_res;
            mem_is_load_q  <= bus.ex_is_load;
            mem_is_store_q <= bus.ex_is_store;
            mem_st_data_q  <= bus.ex_st_data;
        end
    end

    // MEM/WB register, wait-state and stall counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            wb_valid_q <= 1'b0;
            wb_rf_we_q <= 1'b0;
            wb_rf_wa_q <= 5'd0;
            wb_wd_q    <= 32'd0;
            perf_q     <= '0;
        end else begin
            state_q    <= state_d;
            wb_valid_q <= wb_valid_d;
            wb_rf_we_q <= wb_rf_we_d;
            wb_rf_wa_q <= wb_rf_wa_d;
            wb_wd_q    <= wb_wd_d;
            perf_q     <= perf_d;
        end
    end

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Bench for mem_wb_pipe: directed scenarios plus a randomized instruction stream against an instruction-level model.
// Latency: checks sampled on the falling edge, inputs driven 1ns after the rising edge.
// Backpressure: the bench emulates the front end, holding EX on stall_ex and inserting a bubble on flush_ex.
`timescale 1ns/1ps
module tb_mem_wb_pipe;
    localparam int PERF_W = 32;

    typedef struct packed {
        logic        v;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] res;
        logic        ld;
        logic        st;
        logic [31:0] sd;
    } instr_t;

    localparam instr_t BUBBLE = '0;

    logic clk = 1'b0;
    logic rstn;
    int   n_tests = 0;
    int   n_fail  = 0;

    mem_wb_pipe_if #(.PERF_W(PERF_W)) bus ();
    mem_wb_pipe #(.PERF_W(PERF_W)) dut (.clk(clk), .rstn(rstn), .bus(bus));

    always #5 clk = ~clk;

    function automatic instr_t mk(input logic v, input logic we, input logic [4:0] wa,
                                  input logic [31:0] res, input logic ld, input logic st,
                                  input logic [31:0] sd);
        instr_t i;
        i.v = v; i.we = we; i.wa = wa; i.res = res; i.ld = ld; i.st = st; i.sd = sd;
        return i;
    endfunction

    task automatic set_ex(input instr_t i);
        bus.ex_valid    = i.v;
        bus.ex_rf_we    = i.we;
        bus.ex_rf_wa    = i.wa;
        bus.ex_alu_res  = i.res;
        bus.ex_is_load  = i.ld;
        bus.ex_is_store = i.st;
        bus.ex_st_data  = i.sd;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        set_ex(BUBBLE);
        bus.id_ra0 = 5'd0; bus.id_ra1 = 5'd0;
        bus.dm_ready = 1'b0; bus.dm_rdata = 32'd0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    function automatic logic [3:0] stalls();
        return {bus.stall_if, bus.stall_id, bus.stall_ex, bus.flush_ex};
    endfunction

    task automatic test_reset();
        rstn = 1'b0;
        set_ex(mk(1, 1, 5'd7, 32'h22, 0, 0, 0));
        bus.id_ra0 = 5'd0; bus.id_ra1 = 5'd0;
        bus.dm_ready = 1'b0; bus.dm_rdata = 32'd0;
        #2;
        n_tests++;
        if ({bus.dm_req, bus.rf_we_mem, bus.rf_we_wb, stalls()} !== 7'b0) begin
            n_fail++; $display("FAIL reset_outputs got %b exp 0", {bus.dm_req, bus.rf_we_mem, bus.rf_we_wb, stalls()});
        end
        n_tests++;
        if (bus.perf_stall !== '0) begin
            n_fail++; $display("FAIL reset_perf got %0d exp 0", bus.perf_stall);
        end
        next();
        n_tests++;
        if (bus.rf_we_mem !== 1'b0) begin
            n_fail++; $display("FAIL reset_hold_mem got %b exp 0", bus.rf_we_mem);
        end
        rstn = 1'b1;
        next();
        set_ex(BUBBLE);
        @(negedge clk);
        n_tests++;
        if ({bus.rf_we_mem, bus.rf_wa_mem, bus.rf_wd_mem} !== {1'b1, 5'd7, 32'h22}) begin
            n_fail++; $display("FAIL first_capture got %b/%0d/%h exp 1/7/22", bus.rf_we_mem, bus.rf_wa_mem, bus.rf_wd_mem);
        end
    endtask

    task automatic test_alu_fwd();
        do_reset();
        bus.dm_ready = 1'b1;
        set_ex(mk(1, 1, 5'd5, 32'h11, 0, 0, 0));
        next();
        set_ex(BUBBLE);
        @(negedge clk);
        n_tests++;
        if ({bus.rf_we_mem, bus.rf_wa_mem, bus.rf_wd_mem, bus.dm_req} !== {1'b1, 5'd5, 32'h11, 1'b0}) begin
            n_fail++; $display("FAIL alu_mem got %b/%0d/%h req %b exp 1/5/11 req 0", bus.rf_we_mem, bus.rf_wa_mem, bus.rf_wd_mem, bus.dm_req);
        end
        next();
        @(negedge clk);
        n_tests++;
        if ({bus.rf_we_wb, bus.rf_wa_wb, bus.rf_wd_wb, bus.rf_we_mem} !== {1'b1, 5'd5, 32'h11, 1'b0}) begin
            n_fail++; $display("FAIL alu_wb got %b/%0d/%h mem %b exp 1/5/11 mem 0", bus.rf_we_wb, bus.rf_wa_wb, bus.rf_wd_wb, bus.rf_we_mem);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        bus.dm_ready = 1'b1; bus.dm_rdata = 32'hCAFE;
        set_ex(mk(1, 1, 5'd3, 32'h80, 1, 0, 0));
        bus.id_ra0 = 5'd7; bus.id_ra1 = 5'd3;
        @(negedge clk);
        n_tests++;
        if (stalls() !== 4'b1101) begin
            n_fail++; $display("FAIL lu_stall got %b exp 1101", stalls());
        end
        next();
        set_ex(BUBBLE);
        @(negedge clk);
        n_tests++;
        if ({stalls(), bus.dm_req, bus.dm_we, bus.dm_addr, bus.rf_we_mem} !== {4'b0000, 1'b1, 1'b0, 32'h80, 1'b0}) begin
            n_fail++; $display("FAIL lu_mem got st %b req %b we %b addr %h fwd %b exp 0000/1/0/80/0",
                               stalls(), bus.dm_req, bus.dm_we, bus.dm_addr, bus.rf_we_mem);
        end
        next();
        bus.id_ra0 = 5'd0; bus.id_ra1 = 5'd0;
        @(negedge clk);
        n_tests++;
        if ({bus.rf_we_wb, bus.rf_wa_wb, bus.rf_wd_wb, bus.perf_stall} !== {1'b1, 5'd3, 32'hCAFE, 32'd1}) begin
            n_fail++; $display("FAIL lu_wb got %b/%0d/%h perf %0d exp 1/3/cafe perf 1", bus.rf_we_wb, bus.rf_wa_wb, bus.rf_wd_wb, bus.perf_stall);
        end
    endtask

    task automatic test_store_wait();
        do_reset();
        set_ex(mk(1, 0, 5'd0, 32'h40, 0, 1, 32'hDEAD));
        next();
        set_ex(BUBBLE);
        for (int i = 0; i < 4; i++) begin
            bus.dm_ready = (i == 3);
            @(negedge clk);
            n_tests++;
            if ({bus.dm_req, bus.dm_we, bus.dm_addr, bus.dm_wdata} !== {1'b1, 1'b1, 32'h40, 32'hDEAD}) begin
                n_fail++; $display("FAIL st_req[%0d] got %b/%b/%h/%h exp 1/1/40/dead", i, bus.dm_req, bus.dm_we, bus.dm_addr, bus.dm_wdata);
            end
            n_tests++;
            if ({stalls(), bus.rf_we_wb} !== {((i < 3) ? 4'b1110 : 4'b0000), 1'b0}) begin
                n_fail++; $display("FAIL st_stall[%0d] got %b wb %b exp %b wb 0", i, stalls(), bus.rf_we_wb, (i < 3) ? 4'b1110 : 4'b0000);
            end
            next();
        end
        @(negedge clk);
        n_tests++;
        if ({bus.dm_req, bus.rf_we_wb, bus.perf_stall} !== {1'b0, 1'b0, 32'd3}) begin
            n_fail++; $display("FAIL st_done got req %b wb %b perf %0d exp 0/0/3", bus.dm_req, bus.rf_we_wb, bus.perf_stall);
        end
    endtask

    task automatic test_lu_with_stall();
        do_reset();
        set_ex(mk(1, 0, 5'd0, 32'h44, 0, 1, 32'h1));
        next();
        set_ex(mk(1, 1, 5'd6, 32'h48, 1, 0, 0));
        bus.id_ra0 = 5'd6; bus.id_ra1 = 5'd0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_tests++;
            if (stalls() !== 4'b1110) begin
                n_fail++; $display("FAIL lu_memstall[%0d] got %b exp 1110", k, stalls());
            end
            next();
        end
        bus.dm_ready = 1'b1; bus.dm_rdata = 32'hBEEF;
        @(negedge clk);
        n_tests++;
        if (stalls() !== 4'b1101) begin
            n_fail++; $display("FAIL lu_after_ready got %b exp 1101", stalls());
        end
        next();
        set_ex(BUBBLE);
        @(negedge clk);
        n_tests++;
        if ({stalls(), bus.dm_req, bus.dm_addr, bus.perf_stall} !== {4'b0000, 1'b1, 32'h48, 32'd3}) begin
            n_fail++; $display("FAIL lu_single_bubble got st %b req %b addr %h perf %0d exp 0000/1/48/3",
                               stalls(), bus.dm_req, bus.dm_addr, bus.perf_stall);
        end
        next();
        @(negedge clk);
        n_tests++;
        if ({bus.rf_we_wb, bus.rf_wa_wb, bus.rf_wd_wb} !== {1'b1, 5'd6, 32'hBEEF}) begin
            n_fail++; $display("FAIL lu_stall_wb got %b/%0d/%h exp 1/6/beef", bus.rf_we_wb, bus.rf_wa_wb, bus.rf_wd_wb);
        end
    endtask

    task automatic test_x0();
        do_reset();
        bus.dm_ready = 1'b1; bus.dm_rdata = 32'h5;
        set_ex(mk(1, 1, 5'd0, 32'h99, 0, 0, 0));
        next();
        set_ex(mk(1, 1, 5'd0, 32'h10, 1, 0, 0));
        @(negedge clk);
        n_tests++;
        if ({bus.rf_we_mem, stalls()} !== 5'b0) begin
            n_fail++; $display("FAIL x0_mem got fwd %b st %b exp 0/0000", bus.rf_we_mem, stalls());
        end
        next();
        set_ex(BUBBLE);
        @(negedge clk);
        n_tests++;
        if (bus.rf_we_wb !== 1'b0) begin
            n_fail++; $display("FAIL x0_alu_wb got %b exp 0", bus.rf_we_wb);
        end
        next();
        @(negedge clk);
        n_tests++;
        if (bus.rf_we_wb !== 1'b0) begin
            n_fail++; $display("FAIL x0_load_wb got %b exp 0", bus.rf_we_wb);
        end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        set_ex(mk(1, 0, 5'd0, 32'h50, 0, 1, 32'h5));
        next();
        set_ex(mk(1, 1, 5'd9, 32'h1, 0, 0, 0));
        next();
        @(negedge clk);
        n_tests++;
        if ({bus.dm_req, bus.perf_stall} !== {1'b1, 32'd1}) begin
            n_fail++; $display("FAIL wait_before_rst got req %b perf %0d exp 1/1", bus.dm_req, bus.perf_stall);
        end
        #1 rstn = 1'b0;
        #1;
        n_tests++;
        if ({bus.dm_req, bus.rf_we_mem, bus.rf_we_wb, bus.stall_if, bus.perf_stall} !== {4'b0, 32'd0}) begin
            n_fail++; $display("FAIL rst_in_wait got req %b fwd %b wb %b stall %b perf %0d exp all 0",
                               bus.dm_req, bus.rf_we_mem, bus.rf_we_wb, bus.stall_if, bus.perf_stall);
        end
        next();
        rstn = 1'b1;
        set_ex(BUBBLE);
        bus.dm_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_tests++;
            if ({bus.dm_req, bus.rf_we_mem, bus.rf_we_wb} !== 3'b000) begin
                n_fail++; $display("FAIL post_rst[%0d] got %b exp 000", k, {bus.dm_req, bus.rf_we_mem, bus.rf_we_wb});
            end
            next();
        end
    endtask

    function automatic instr_t rand_instr();
        instr_t i;
        int     kind;
        kind  = $urandom_range(0, 3);
        i.v   = ($urandom_range(0, 9) != 0);
        i.ld  = (kind == 1);
        i.st  = (kind == 2);
        i.we  = i.st ? 1'b0 : ($urandom_range(0, 7) != 0);
        i.wa  = 5'($urandom_range(0, 7));
        i.res = $urandom;
        i.sd  = $urandom;
        return i;
    endfunction

    // Instruction-level model: one record in MEM, one in WB, a stall counter.
    task automatic test_random(input int n);
        instr_t            ex_s, mm, wb;
        logic [4:0]        ra0, ra1;
        logic              rdy, acc, busy, hz, exp_we_mem, exp_we_wb;
        logic [31:0]       rd;
        logic [3:0]        exp_st;
        logic [PERF_W-1:0] perf;
        do_reset();
        mm = BUBBLE; wb = BUBBLE; perf = '0;
        ex_s = rand_instr();
        ra0 = 5'($urandom_range(0, 7)); ra1 = 5'($urandom_range(0, 7));
        rdy = $urandom_range(0, 1) == 1; rd = $urandom;
        for (int c = 0; c < n; c++) begin
            set_ex(ex_s);
            bus.id_ra0 = ra0; bus.id_ra1 = ra1;
            bus.dm_ready = rdy; bus.dm_rdata = rd;
            @(negedge clk);
            acc        = mm.v && (mm.ld || mm.st);
            busy       = acc && !rdy;
            hz         = ex_s.v && ex_s.ld && ex_s.we && ex_s.wa != 0 && (ex_s.wa == ra0 || ex_s.wa == ra1);
            exp_st     = busy ? 4'b1110 : (hz ? 4'b1101 : 4'b0000);
            exp_we_mem = mm.v && mm.we && !mm.ld && mm.wa != 0;
            exp_we_wb  = wb.v && wb.we && wb.wa != 0;
            n_tests++;
            if ({stalls(), bus.dm_req} !== {exp_st, acc}) begin
                n_fail++; $display("FAIL rnd_ctl[%0d] got st %b req %b exp %b/%b", c, stalls(), bus.dm_req, exp_st, acc);
            end
            if (acc) begin
                n_tests++;
                if ({bus.dm_we, bus.dm_addr, bus.dm_wdata} !== {mm.st, mm.res, mm.sd}) begin
                    n_fail++; $display("FAIL rnd_dm[%0d] got %b/%h/%h exp %b/%h/%h", c, bus.dm_we, bus.dm_addr, bus.dm_wdata, mm.st, mm.res, mm.sd);
                end
            end
            n_tests++;
            if (bus.rf_we_mem !== exp_we_mem || (exp_we_mem && {bus.rf_wa_mem, bus.rf_wd_mem} !== {mm.wa, mm.res})) begin
                n_fail++; $display("FAIL rnd_fwd[%0d] got %b/%0d/%h exp %b/%0d/%h", c, bus.rf_we_mem, bus.rf_wa_mem, bus.rf_wd_mem, exp_we_mem, mm.wa, mm.res);
            end
            n_tests++;
            if (bus.rf_we_wb !== exp_we_wb || (exp_we_wb && {bus.rf_wa_wb, bus.rf_wd_wb} !== {wb.wa, wb.res})) begin
                n_fail++; $display("FAIL rnd_wb[%0d] got %b/%0d/%h exp %b/%0d/%h", c, bus.rf_we_wb, bus.rf_wa_wb, bus.rf_wd_wb, exp_we_wb, wb.wa, wb.res);
            end
            n_tests++;
            if (bus.perf_stall !== perf) begin
                n_fail++; $display("FAIL rnd_perf[%0d] got %0d exp %0d", c, bus.perf_stall, perf);
            end
            next();
            if (busy || hz) perf = perf + 1'b1;
            if (busy) begin
                wb = BUBBLE;
            end else begin
                wb = mm;
                if (mm.ld) wb.res = rd;
                mm = ex_s;
            end
            if (!busy) begin
                if (hz) begin
                    ex_s = BUBBLE;
                end else begin
                    ex_s = rand_instr();
                    ra0 = ($urandom_range(0, 2) == 0) ? ex_s.wa : 5'($urandom_range(0, 7));
                    ra1 = 5'($urandom_range(0, 7));
                end
            end
            rdy = $urandom_range(0, 1) == 1;
            rd  = $urandom;
        end
    endtask

    initial begin
        test_reset();
        test_alu_fwd();
        test_load_use();
        test_store_wait();
        test_lu_with_stall();
        test_x0();
        test_reset_mid_wait();
        test_random(600);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
